alu_arbiter: RTL
================

Name: alu_arbiter

Overview:
- Shares the single 16-bit ALU between two requesters (req0 = execute stage, req1 = auxiliary/debug port).
- Round-robin arbitration with a valid/ready handshake on each requester port.
- Sequences one operation at a time through the clocked ALU, waits ALU_LATENCY cycles, then returns the result and flags.
- Owns the architectural status-flag register.

Parameters:
- ALU_LATENCY, 1: clock cycles from driving the ALU inputs to sampling alu_result/alu_flags; legal range 1..7.
- WIDTH, 16: data width of operands and result.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_op  in  3  opcode: 000 ADD, 001 NOT, 010 NOP.
- req0_src  in  WIDTH  source operand.
- req0_dst  in  WIDTH  destination operand.
- req1_valid, req1_ready, req1_op, req1_src, req1_dst: same as req0, for requester 1.
- alu_op  out  3  opcode driven to the ALU.
- alu_src  out  WIDTH  source operand driven to the ALU.
- alu_dst  out  WIDTH  destination operand driven to the ALU.
- alu_result  in  WIDTH  ALU result.
- alu_flags  in  4  ALU flags: bit0 carry, bit1 zero, bit2 negative, bit3 overflow.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts the response.
- rsp_id  out  1  requester that owns the response.
- rsp_result  out  WIDTH  captured result.
- rsp_flags  out  4  status flags after this operation.
- rsp_err  out  1  illegal opcode.
- status_flags  out  4  architectural flag register.

Behaviour:
- Reset (async, immediate):
  - State IDLE.
  - All outputs 0, except alu_op = 010 (NOP).
  - last_grant = 1, so req0 wins the first tie.
  - Any in-flight operation is discarded; no response is produced for it.
- States: IDLE -> WAIT -> RESP -> IDLE. An illegal opcode goes IDLE -> RESP directly.
- IDLE, arbitration:
  - Only one valid: grant it.
  - Both valid: grant the requester != last_grant.
  - reqN_ready is combinational: high only in IDLE and only for the granted N. The other ready stays 0.
- Accept (valid && ready at edge T):
  - Latch op, src, dst and id; set last_grant = id; load counter = ALU_LATENCY.
  - Go to WAIT, or to RESP if the opcode is illegal.
- WAIT:
  - alu_op/alu_src/alu_dst are driven from the latched registers, stable for the whole state.
  - The counter decrements each cycle. At the edge where it reaches 0, capture alu_result/alu_flags and go to RESP.
  - For ALU_LATENCY = 1, rsp_valid rises at T+2.
  - Outside WAIT, alu_op = 010 and the operands hold their last values.
- Flag update at capture:
  - ADD: status_flags <= alu_flags (all 4 bits).
  - NOT: only bit1 (zero) is taken from alu_flags; bits 0, 2, 3 are retained.
  - NOP: status_flags unchanged; rsp_result = 0.
  - rsp_flags always equals the post-update status_flags.
- Illegal opcodes (011, 1xx):
  - ALU is not driven (alu_op stays 010); no flag update.
  - rsp_result = 0, rsp_err = 1.
  - rsp_valid at T+1.
- RESP:
  - rsp_valid held high, outputs stable until rsp_valid && rsp_ready. Backpressure is unbounded.
  - On handshake: go to IDLE, rsp_valid = 0.
  - A new accept is possible in the cycle after the handshake, not in the same cycle.
- reqN inputs are ignored while not in IDLE. Requesters must hold valid/op/operands stable until ready.
- Throughput: one operation per (ALU_LATENCY + 2) cycles minimum, given rsp_ready = 1.

Optional Feature:
- Macro ALU_ARBITER_SUB_EN.
- Defined:
  - Opcode 011 = SUB, a legal opcode sent to the ALU as 011.
  - Flag handling is identical to ADD (all 4 flags updated from alu_flags).
- Undefined: 011 is illegal, handled per the illegal-opcode rules above.

Test Plan:
1. Reset mid-WAIT: assert rst while an ADD is in flight -> all outputs 0 immediately, alu_op = 010, no rsp_valid after release; next accept goes to req0.
2. Single ADD via req0, src = 16'h7FFF, dst = 16'h0001, ALU_LATENCY = 1, ALU model returns 16'h8000 / flags 4'b1100 -> rsp_valid at T+2, rsp_id = 0, rsp_result = 8000, rsp_flags = status_flags = 1100.
3. Both requesters valid continuously, rsp_ready = 1 -> grants alternate 0, 1, 0, 1; no requester is granted twice in a row; ready is never high on both ports.
4. Seed status_flags = 4'b1101 via ADD, then NOT with dst = 16'hFFFF (ALU returns 0000, zero flag = 1) -> rsp_flags = 1111 (bits 0, 2, 3 retained).
5. Illegal op 3'b101 on req1 -> rsp_valid at T+1, rsp_err = 1, rsp_result = 0, alu_op remains 010, status_flags unchanged.
6. rsp_ready held 0 for 10 cycles with req0 valid -> rsp outputs stable throughout, req0_ready = 0 throughout; req0 accepted in the cycle after the handshake.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one clocked ALU between two requesters; owns the status flags.
// Optional ALU_ARBITER_SUB_EN makes opcode 011 (SUB) legal; otherwise 011 is illegal.
module alu_arbiter #(
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned WIDTH       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [2:0]       req0_op,
    input  logic [WIDTH-1:0] req0_src,
    input  logic [WIDTH-1:0] req0_dst,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [2:0]       req1_op,
    input  logic [WIDTH-1:0] req1_src,
    input  logic [WIDTH-1:0] req1_dst,
    output logic [2:0]       alu_op,
    output logic [WIDTH-1:0] alu_src,
    output logic [WIDTH-1:0] alu_dst,
    input  logic [WIDTH-1:0] alu_result,
    input  logic [3:0]       alu_flags,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic [3:0]       rsp_flags,
    output logic             rsp_err,
    output logic [3:0]       status_flags
);

    localparam int unsigned OP_W   = 3;
    localparam int unsigned FLAG_W = 4;
    localparam int unsigned CNT_W  = 3;

    localparam logic [OP_W-1:0] OP_ADD = 3'b000;
    localparam logic [OP_W-1:0] OP_NOT = 3'b001;
    localparam logic [OP_W-1:0] OP_NOP = 3'b010;
    localparam logic [OP_W-1:0] OP_SUB = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state,        w_state_nxt;
    logic                r_last_grant,   w_last_grant_nxt;
    logic [CNT_W-1:0]    r_cnt,          w_cnt_nxt;
    logic [OP_W-1:0]     r_alu_op,       w_alu_op_nxt;
    logic [WIDTH-1:0]    r_alu_src,      w_alu_src_nxt;
    logic [WIDTH-1:0]    r_alu_dst,      w_alu_dst_nxt;
    logic                r_rsp_valid,    w_rsp_valid_nxt;
    logic                r_rsp_id,       w_rsp_id_nxt;
    logic [WIDTH-1:0]    r_rsp_result,   w_rsp_result_nxt;
    logic [FLAG_W-1:0]   r_rsp_flags,    w_rsp_flags_nxt;
    logic                r_rsp_err,      w_rsp_err_nxt;
    logic [FLAG_W-1:0]   r_status,       w_status_nxt;

    logic                w_any_valid;
    logic                w_grant_id;
    logic [OP_W-1:0]     w_sel_op;
    logic [WIDTH-1:0]    w_sel_src;
    logic [WIDTH-1:0]    w_sel_dst;
    logic                w_sel_legal;
    logic [FLAG_W-1:0]   w_flags_upd;

    function automatic logic op_is_legal(input logic [OP_W-1:0] op);
`ifdef ALU_ARBITER_SUB_EN
        return (op == OP_ADD) || (op == OP_NOT) || (op == OP_NOP) || (op == OP_SUB);
`else
        return (op == OP_ADD) || (op == OP_NOT) || (op == OP_NOP);
`endif
    endfunction

    // Round-robin pick: a tie goes to the requester that was not granted last.
    always_comb begin
        w_any_valid = req0_valid | req1_valid;
        if (req0_valid && req1_valid) begin
            w_grant_id = ~r_last_grant;
        end else begin
            w_grant_id = req1_valid;
        end
        w_sel_op    = w_grant_id ? req1_op  : req0_op;
        w_sel_src   = w_grant_id ? req1_src : req0_src;
        w_sel_dst   = w_grant_id ? req1_dst : req0_dst;
        w_sel_legal = op_is_legal(w_sel_op);
    end

    assign req0_ready = (r_state == S_IDLE) && w_any_valid && !w_grant_id;
    assign req1_ready = (r_state == S_IDLE) && w_any_valid &&  w_grant_id;

    // NOT only refreshes the zero flag; arithmetic ops replace all four.
    always_comb begin
        w_flags_upd = r_status;
        unique case (r_alu_op)
            OP_ADD:  w_flags_upd = alu_flags;
            OP_NOT:  w_flags_upd = {r_status[3:2], alu_flags[1], r_status[0]};
`ifdef ALU_ARBITER_SUB_EN
            OP_SUB:  w_flags_upd = alu_flags;
`endif
            default: w_flags_upd = r_status;
        endcase
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_last_grant_nxt = r_last_grant;
        w_cnt_nxt        = r_cnt;
        w_alu_op_nxt     = r_alu_op;
        w_alu_src_nxt    = r_alu_src;
        w_alu_dst_nxt    = r_alu_dst;
        w_rsp_valid_nxt  = r_rsp_valid;
        w_rsp_id_nxt     = r_rsp_id;
        w_rsp_result_nxt = r_rsp_result;
        w_rsp_flags_nxt  = r_rsp_flags;
        w_rsp_err_nxt    = r_rsp_err;
        w_status_nxt     = r_status;

        unique case (r_state)
            S_IDLE: begin
                if (w_any_valid) begin
                    w_last_grant_nxt = w_grant_id;
                    w_rsp_id_nxt     = w_grant_id;
                    if (w_sel_legal) begin
                        w_alu_op_nxt  = w_sel_op;
                        w_alu_src_nxt = w_sel_src;
                        w_alu_dst_nxt = w_sel_dst;
                        w_cnt_nxt     = CNT_W'(ALU_LATENCY);
                        w_state_nxt   = S_WAIT;
                    end else begin
                        // Illegal opcode never reaches the ALU and leaves flags alone.
                        w_rsp_valid_nxt  = 1'b1;
                        w_rsp_result_nxt = '0;
                        w_rsp_flags_nxt  = r_status;
                        w_rsp_err_nxt    = 1'b1;
                        w_state_nxt      = S_RESP;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 3'd1;
                if (r_cnt == 3'd1) begin
                    w_status_nxt     = w_flags_upd;
                    w_rsp_flags_nxt  = w_flags_upd;
                    w_rsp_result_nxt = (r_alu_op == OP_NOP) ? '0 : alu_result;
                    w_rsp_err_nxt    = 1'b0;
                    w_rsp_valid_nxt  = 1'b1;
                    w_alu_op_nxt     = OP_NOP;
                    w_state_nxt      = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_state_nxt     = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_cnt        <= '0;
            r_alu_op     <= OP_NOP;
            r_alu_src    <= '0;
            r_alu_dst    <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_id     <= 1'b0;
            r_rsp_result <= '0;
            r_rsp_flags  <= '0;
            r_rsp_err    <= 1'b0;
            r_status     <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last_grant <= w_last_grant_nxt;
            r_cnt        <= w_cnt_nxt;
            r_alu_op     <= w_alu_op_nxt;
            r_alu_src    <= w_alu_src_nxt;
            r_alu_dst    <= w_alu_dst_nxt;
            r_rsp_valid  <= w_rsp_valid_nxt;
            r_rsp_id     <= w_rsp_id_nxt;
            r_rsp_result <= w_rsp_result_nxt;
            r_rsp_flags  <= w_rsp_flags_nxt;
            r_rsp_err    <= w_rsp_err_nxt;
            r_status     <= w_status_nxt;
        end
    end

    assign alu_op       = r_alu_op;
    assign alu_src      = r_alu_src;
    assign alu_dst      = r_alu_dst;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_result   = r_rsp_result;
    assign rsp_flags    = r_rsp_flags;
    assign rsp_err      = r_rsp_err;
    assign status_flags = r_status;

endmodule
